jtag_dr_engine: RTL and testbench

//  User-side responder for the virtual JTAG hub. Decodes the 2-bit virtual IR, owns the DR shift

---
 rtl/jtag_dr_pkg.sv | 12 +
 rtl/jtag_dr_engine_if.sv | 11 +
 rtl/jtag_req_hs.sv | 49 ++++
 rtl/jtag_dr_engine.sv | 86 ++++++++
 tb/tb_jtag_dr_engine.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/jtag_dr_pkg.sv
// jtag_dr_pkg: shared IR codes and handshake state encoding for the virtual JTAG DR engine
package jtag_dr_pkg;
  localparam logic [1:0] IR_BYPASS = 2'b00;
  localparam logic [1:0] IR_ADDR   = 2'b01;
  localparam logic [1:0] IR_WRITE  = 2'b10;
  localparam logic [1:0] IR_READ   = 2'b11;
  typedef enum logic [1:0] {
    HS_IDLE  = 2'b00,
    HS_REQ   = 2'b01,
    HS_ACKLO = 2'b10
  } hs_state_t;
endpackage

// File: rtl/jtag_dr_engine_if.sv
// jtag_dr_engine_if: four-phase bus port between the DR engine (master) and the CDC block (slave)
interface jtag_dr_engine_if #(parameter int W = 32);
  logic         bus_req;
  logic         bus_we;
  logic [W-1:0] bus_addr;
  logic [W-1:0] bus_wdata;
  logic         bus_ack;
  logic [W-1:0] bus_rdata;
  modport master (output bus_req, bus_we, bus_addr, bus_wdata, input bus_ack, bus_rdata);
  modport slave  (input bus_req, bus_we, bus_addr, bus_wdata, output bus_ack, bus_rdata);
endinterface

// File: rtl/jtag_req_hs.sv
// jtag_req_hs: four-phase request/acknowledge FSM; done/done_rd strobe on the edge that accepts ack
module jtag_req_hs
  import jtag_dr_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic we,
  input  logic bus_ack,
  output logic bus_req,
  output logic busy,
  output logic done,
  output logic done_rd
);
  hs_state_t state;
  logic      we_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= HS_IDLE;
      bus_req <= 1'b0;
      busy    <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      unique case (state)
        HS_IDLE: if (start) begin
          state   <= HS_REQ;
          bus_req <= 1'b1;
          busy    <= 1'b1;
          we_q    <= we;
        end
        HS_REQ: if (bus_ack) begin
          state   <= HS_ACKLO;
          bus_req <= 1'b0;
        end
        HS_ACKLO: if (!bus_ack) begin
          state <= HS_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= HS_IDLE;
          bus_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end
  assign done    = (state == HS_REQ) && bus_ack;
  assign done_rd = done && !we_q;
endmodule

// File: rtl/jtag_dr_engine.sv
// jtag_dr_engine: virtual JTAG user-side DR chains turning update-DR into single bus transactions
// Optional JTAG_AUTOINC_EN: bus_addr advances by ADDR_STEP after each completed transaction.
module jtag_dr_engine
  import jtag_dr_pkg::*;
#(
  parameter int W         = 32,
  parameter int ADDR_STEP = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tdi,
  output logic                    tdo,
  input  logic [1:0]              ir_in,
  output logic [1:0]              ir_out,
  input  logic                    vs_cdr,
  input  logic                    vs_sdr,
  input  logic                    vs_udr,
  input  logic                    vs_uir,
  jtag_dr_engine_if.master        bus
);
`ifdef JTAG_AUTOINC_EN
  localparam logic AUTOINC = 1'b1;
`else
  localparam logic AUTOINC = 1'b0;
`endif
  logic [W-1:0] shreg;
  logic [W-1:0] rdata_q;
  logic         bypass;
  logic         overrun;
  logic         busy;
  logic         done;
  logic         done_rd;
  logic         start;
  logic         unused_ok;
  // ir_out is driven continuously, so update-IR needs no action of its own
  assign unused_ok = vs_uir;
  assign start     = vs_udr && ir_in[1];
  assign tdo       = (ir_in == IR_BYPASS) ? bypass : shreg[0];
  assign ir_out    = {busy, overrun};
  jtag_req_hs u_hs (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .we      (ir_in == IR_WRITE),
    .bus_ack (bus.bus_ack),
    .bus_req (bus.bus_req),
    .busy    (busy),
    .done    (done),
    .done_rd (done_rd)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg         <= '0;
      bypass        <= 1'b0;
      rdata_q       <= '0;
      overrun       <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
    end else begin
      if (vs_cdr)
        shreg <= (ir_in == IR_ADDR)  ? bus.bus_addr  :
                 (ir_in == IR_WRITE) ? bus.bus_wdata :
                 (ir_in == IR_READ)  ? rdata_q       : shreg;
      if (vs_cdr && ir_in == IR_BYPASS)
        bypass <= 1'b0;
      if (vs_sdr) begin
        shreg  <= {tdi, shreg[W-1:1]};
        bypass <= tdi;
      end
      // any non-bypass update landing while busy is dropped and flagged
      if (vs_udr && ir_in != IR_BYPASS)
        overrun <= busy ? 1'b1 : (ir_in == IR_ADDR) ? 1'b0 : overrun;
      if (vs_udr && !busy && ir_in == IR_ADDR)
        bus.bus_addr <= shreg;
      else if (AUTOINC && done)
        bus.bus_addr <= bus.bus_addr + W'(ADDR_STEP);
      if (vs_udr && !busy && ir_in == IR_WRITE)
        bus.bus_wdata <= shreg;
      if (start && !busy)
        bus.bus_we <= (ir_in == IR_WRITE);
      if (done_rd)
        rdata_q <= bus.bus_rdata;
    end
  end
endmodule

// File: tb/tb_jtag_dr_engine.sv
// tb_jtag_dr_engine: scoreboard bench; expected bus transactions are queued at update and checked at bus_req
module tb_jtag_dr_engine;
  import jtag_dr_pkg::*;
  localparam int W = 32;
`ifdef JTAG_AUTOINC_EN
  localparam logic [W-1:0] STEP = 32'd4;
`else
  localparam logic [W-1:0] STEP = 32'd0;
`endif
  typedef struct {
    logic         we;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
  } txn_t;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tdi = 1'b0;
  logic         tdo;
  logic [1:0]   ir_in = 2'b00;
  logic [1:0]   ir_out;
  logic         vs_cdr = 1'b0;
  logic         vs_sdr = 1'b0;
  logic         vs_udr = 1'b0;
  logic         vs_uir = 1'b0;
  int           n_checks = 0;
  int           n_fail = 0;
  int           req_count = 0;
  int           ack_dly = 2;
  bit           ack_hold = 1'b0;
  logic [W-1:0] rd_val = '0;
  logic [W-1:0] m_addr = '0;
  txn_t         sb_q[$];
  jtag_dr_engine_if #(.W(W)) bus ();
  jtag_dr_engine #(.W(W), .ADDR_STEP(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .tdi    (tdi),
    .tdo    (tdo),
    .ir_in  (ir_in),
    .ir_out (ir_out),
    .vs_cdr (vs_cdr),
    .vs_sdr (vs_sdr),
    .vs_udr (vs_udr),
    .vs_uir (vs_uir),
    .bus    (bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic push(input logic we, input logic [W-1:0] addr, input logic [W-1:0] wdata);
    txn_t t;
    t.we = we;
    t.addr = addr;
    t.wdata = wdata;
    sb_q.push_back(t);
  endtask
  task automatic scan(input logic [1:0] ir, input logic [W-1:0] d, input bit upd, output logic [W-1:0] q);
    @(negedge clk);
    ir_in = ir;
    vs_cdr = 1'b1;
    @(negedge clk);
    vs_cdr = 1'b0;
    vs_sdr = 1'b1;
    for (int i = 0; i < W; i++) begin
      tdi = d[i];
      q[i] = tdo;
      @(negedge clk);
    end
    vs_sdr = 1'b0;
    tdi = 1'b0;
    if (upd) begin
      vs_udr = 1'b1;
      @(negedge clk);
      vs_udr = 1'b0;
    end
  endtask
  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((ir_out[1] || bus.bus_ack) && n < 200);
    if (n >= 200) check("idle_timeout", 64'(0), 64'(1));
  endtask
  // bus slave: checks each new request against the scoreboard, then completes the four-phase cycle
  initial begin
    txn_t e;
    int   n;
    bus.bus_ack = 1'b0;
    bus.bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.bus_req && !bus.bus_ack) begin
        req_count++;
        if (sb_q.size() == 0) begin
          check("unexpected_req", 64'(1), 64'(0));
        end else begin
          e = sb_q.pop_front();
          check("req_we", 64'(bus.bus_we), 64'(e.we));
          check("req_addr", 64'(bus.bus_addr), 64'(e.addr));
          if (e.we) check("req_wdata", 64'(bus.bus_wdata), 64'(e.wdata));
        end
        repeat (ack_dly) @(negedge clk);
        while (ack_hold) @(negedge clk);
        bus.bus_ack = 1'b1;
        bus.bus_rdata = rd_val;
        n = 0;
        while (bus.bus_req && n < 50) begin
          @(negedge clk);
          n++;
        end
        if (n >= 50) check("req_drop_timeout", 64'(0), 64'(1));
        bus.bus_ack = 1'b0;
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [W-1:0] q;
    logic [7:0]   pat;
    logic [7:0]   got;
    int           rc;
    repeat (2) @(negedge clk);
    check("rst_tdo", 64'(tdo), 64'(0));
    check("rst_ir_out", 64'(ir_out), 64'(0));
    check("rst_req", 64'(bus.bus_req), 64'(0));
    check("rst_we", 64'(bus.bus_we), 64'(0));
    check("rst_addr", 64'(bus.bus_addr), 64'(0));
    check("rst_wdata", 64'(bus.bus_wdata), 64'(0));
    rst_n = 1'b1;
    scan(IR_ADDR, 32'h0000_1000, 1'b1, q);
    check("addr_cap_reset", 64'(q), 64'(0));
    m_addr = 32'h0000_1000;
    push(1'b1, m_addr, 32'hDEAD_BEEF);
    scan(IR_WRITE, 32'hDEAD_BEEF, 1'b1, q);
    check("wdata_cap_reset", 64'(q), 64'(0));
    wait_idle();
    m_addr = m_addr + STEP;
    check("write_req_count", 64'(req_count), 64'(1));
    check("write_ir_out", 64'(ir_out), 64'(0));
    scan(IR_ADDR, '0, 1'b0, q);
    check("addr_readback", 64'(q), 64'(m_addr));
    scan(IR_WRITE, '0, 1'b0, q);
    check("wdata_readback", 64'(q), 64'(32'hDEAD_BEEF));
    rd_val = 32'h1234_5678;
    push(1'b0, m_addr, 32'hDEAD_BEEF);
    scan(IR_READ, '0, 1'b1, q);
    check("rdata_cap_reset", 64'(q), 64'(0));
    wait_idle();
    m_addr = m_addr + STEP;
    scan(IR_READ, '0, 1'b0, q);
    check("rdata_pipelined", 64'(q), 64'(32'h1234_5678));
    pat = 8'b1011_0010;
    @(negedge clk);
    ir_in = IR_BYPASS;
    vs_cdr = 1'b1;
    @(negedge clk);
    vs_cdr = 1'b0;
    vs_sdr = 1'b1;
    for (int j = 0; j < 8; j++) begin
      tdi = pat[7-j];
      got[7-j] = tdo;
      @(negedge clk);
    end
    vs_sdr = 1'b0;
    tdi = 1'b0;
    check("bypass_delay", 64'(got), 64'(pat >> 1));
    rc = req_count;
    ack_hold = 1'b1;
    push(1'b1, m_addr, 32'hA5A5_A5A5);
    scan(IR_WRITE, 32'hA5A5_A5A5, 1'b1, q);
    scan(IR_WRITE, 32'h5A5A_5A5A, 1'b1, q);
    check("busy_wdata_cap", 64'(q), 64'(32'hA5A5_A5A5));
    check("overrun_busy_ir_out", 64'(ir_out), 64'(2'b11));
    check("busy_wdata_held", 64'(bus.bus_wdata), 64'(32'hA5A5_A5A5));
    scan(IR_ADDR, 32'h0000_9999, 1'b1, q);
    check("busy_addr_held", 64'(bus.bus_addr), 64'(m_addr));
    ack_hold = 1'b0;
    wait_idle();
    m_addr = m_addr + STEP;
    check("overrun_req_count", 64'(req_count), 64'(rc + 1));
    check("overrun_sticky", 64'(ir_out), 64'(2'b01));
    scan(IR_ADDR, 32'h0000_2000, 1'b1, q);
    check("addr_cap_after_busy", 64'(q), 64'(m_addr));
    check("overrun_cleared", 64'(ir_out), 64'(0));
    scan(IR_ADDR, 32'hFFFF_FFFC, 1'b1, q);
    m_addr = 32'hFFFF_FFFC;
    push(1'b1, m_addr, 32'h0000_0001);
    scan(IR_WRITE, 32'h0000_0001, 1'b1, q);
    wait_idle();
    m_addr = m_addr + STEP;
    push(1'b1, m_addr, 32'h0000_0002);
    scan(IR_WRITE, 32'h0000_0002, 1'b1, q);
    wait_idle();
    m_addr = m_addr + STEP;
    check("wrap_addr_final", 64'(bus.bus_addr), 64'(m_addr));
    ack_hold = 1'b1;
    push(1'b1, m_addr, 32'h1111_1111);
    scan(IR_WRITE, 32'h1111_1111, 1'b1, q);
    check("req_before_reset", 64'(bus.bus_req), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("midrst_req", 64'(bus.bus_req), 64'(0));
    check("midrst_we", 64'(bus.bus_we), 64'(0));
    check("midrst_addr", 64'(bus.bus_addr), 64'(0));
    check("midrst_wdata", 64'(bus.bus_wdata), 64'(0));
    check("midrst_ir_out", 64'(ir_out), 64'(0));
    check("midrst_tdo", 64'(tdo), 64'(0));
    ack_hold = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    rc = req_count;
    scan(IR_ADDR, 32'h0000_3000, 1'b1, q);
    check("post_rst_addr_cap", 64'(q), 64'(0));
    push(1'b1, 32'h0000_3000, 32'h2222_2222);
    scan(IR_WRITE, 32'h2222_2222, 1'b1, q);
    wait_idle();
    check("post_rst_req_count", 64'(req_count), 64'(rc + 1));
    check("post_rst_ir_out", 64'(ir_out), 64'(0));
    check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
